// File: rtl/rv_dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: read-owner tags, FSM states
// and the load-owner helper used when a grant is issued.
package rv_dmem_arb_pkg;

   localparam int unsigned WAIT_CNT_W = 8;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CORE = 2'd1,
      AUX  = 2'd2
   } t_dmem_owner;

   typedef enum logic {
      CORE_PRIO = 1'b0,
      AUX_PRIO  = 1'b1
   } t_dmem_arb_state;

   function automatic t_dmem_owner f_load_owner(input logic core_gnt, input logic core_we,
                                                input logic aux_gnt, input logic aux_we);
      t_dmem_owner own;
      own = NONE;
      if (core_gnt && !core_we)
         own = CORE;
      else if (aux_gnt && !aux_we)
         own = AUX;
      return own;
   endfunction

endpackage

// File: rtl/rv_dmem_arb_if.sv
// Bus bundle between the core memory stage, the aux (loader/debug) port
// and the single-port data SRAM.
interface rv_dmem_arb_if;

   logic        core_req_Q103H;
   logic        core_we_Q103H;
   logic [31:0] core_addr_Q103H;
   logic [31:0] core_wdata_Q103H;
   logic [3:0]  core_be_Q103H;
   logic        core_stall_Q103H;
   logic [31:0] core_rdata_Q104H;
   logic        core_rvalid_Q104H;

   logic        aux_req;
   logic        aux_we;
   logic [31:0] aux_addr;
   logic [31:0] aux_wdata;
   logic [3:0]  aux_be;
   logic        aux_gnt;
   logic [31:0] aux_rdata;
   logic        aux_rvalid;

   logic        mem_cs;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;

   modport slave (
      input  core_req_Q103H, core_we_Q103H, core_addr_Q103H, core_wdata_Q103H, core_be_Q103H,
      output core_stall_Q103H, core_rdata_Q104H, core_rvalid_Q104H,
      input  aux_req, aux_we, aux_addr, aux_wdata, aux_be,
      output aux_gnt, aux_rdata, aux_rvalid,
      output mem_cs, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata
   );

   modport master (
      output core_req_Q103H, core_we_Q103H, core_addr_Q103H, core_wdata_Q103H, core_be_Q103H,
      input  core_stall_Q103H, core_rdata_Q104H, core_rvalid_Q104H,
      output aux_req, aux_we, aux_addr, aux_wdata, aux_be,
      input  aux_gnt, aux_rdata, aux_rvalid,
      input  mem_cs, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata
   );

endinterface

// File: rtl/rv_dmem_arb.sv
// Core/aux arbiter for a single-port data SRAM with anti-starvation for aux.
// CORE_PRIO | core wins, aux waits and counts | AUX_PRIO | aux wins for one cycle
module rv_dmem_arb
   import rv_dmem_arb_pkg::*;
#(
   parameter int unsigned AUX_WAIT_MAX = 8
) (
   input logic           clk,
   input logic           rst,
   rv_dmem_arb_if.slave  bus
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(AUX_WAIT_MAX - 1);

   t_dmem_arb_state       r_state;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   t_dmem_owner           r_rd_owner;

   logic w_core_gnt;
   logic w_aux_gnt;
   logic w_aux_denied;

   always_comb begin
      w_core_gnt = 1'b0;
      w_aux_gnt  = 1'b0;
      if (r_state == AUX_PRIO) begin
         w_aux_gnt  = bus.aux_req;
         w_core_gnt = bus.core_req_Q103H & ~bus.aux_req;
      end else begin
         w_core_gnt = bus.core_req_Q103H;
         w_aux_gnt  = bus.aux_req & ~bus.core_req_Q103H;
      end
   end

   assign w_aux_denied         = bus.aux_req & ~w_aux_gnt;
   assign bus.core_stall_Q103H = bus.core_req_Q103H & ~w_core_gnt;
   assign bus.aux_gnt          = w_aux_gnt;

   always_comb begin
      bus.mem_cs    = w_core_gnt | w_aux_gnt;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_be    = '0;
      if (w_core_gnt) begin
         bus.mem_we    = bus.core_we_Q103H;
         bus.mem_addr  = bus.core_addr_Q103H;
         bus.mem_wdata = bus.core_wdata_Q103H;
         bus.mem_be    = bus.core_be_Q103H;
      end else if (w_aux_gnt) begin
         bus.mem_we    = bus.aux_we;
         bus.mem_addr  = bus.aux_addr;
         bus.mem_wdata = bus.aux_wdata;
         bus.mem_be    = bus.aux_be;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= CORE_PRIO;
         r_wait_cnt <= '0;
         r_rd_owner <= NONE;
      end else begin
         case (r_state)
            CORE_PRIO: if (w_aux_denied && (r_wait_cnt >= WAIT_LAST)) r_state <= AUX_PRIO;
            AUX_PRIO:  r_state <= CORE_PRIO;
            default:   r_state <= CORE_PRIO;
         endcase
         if (w_aux_denied && (r_wait_cnt != '1))
            r_wait_cnt <= r_wait_cnt + 1'b1;
         else if (!w_aux_denied)
            r_wait_cnt <= '0;
         r_rd_owner <= f_load_owner(w_core_gnt, bus.core_we_Q103H, w_aux_gnt, bus.aux_we);
      end
   end

   // Read return is steered purely by the registered owner, so stall never sees mem_rdata.
   assign bus.core_rvalid_Q104H = (r_rd_owner == CORE);
   assign bus.aux_rvalid        = (r_rd_owner == AUX);
   assign bus.core_rdata_Q104H  = (r_rd_owner == CORE) ? bus.mem_rdata : '0;
   assign bus.aux_rdata         = (r_rd_owner == AUX)  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_rv_dmem_arb.sv
// Directed bench for rv_dmem_arb with an SRAM model and a read-response scoreboard.
module tb_rv_dmem_arb;
   import rv_dmem_arb_pkg::*;

   localparam int unsigned WAIT_MAX = 8;
   localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   typedef struct packed {
      t_dmem_owner own;
      logic [31:0] data;
   } rsp_t;

   localparam req_t IDLE = '0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rv_dmem_arb_if bus ();

   rv_dmem_arb #(.AUX_WAIT_MAX(WAIT_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   rsp_t        sb[$];
   logic [31:0] model [256];
   int          checks = 0;
   int          errors = 0;
   logic        pend;
   logic [7:0]  pidx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic req_t ld(input logic [31:0] a);
      return '{req: 1'b1, we: 1'b0, addr: a, wdata: 32'h0, be: 4'hF};
   endfunction

   function automatic req_t st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      return '{req: 1'b1, we: 1'b1, addr: a, wdata: d, be: be};
   endfunction

   task automatic drive(input req_t c, input req_t a);
      bus.core_req_Q103H   = c.req;
      bus.core_we_Q103H    = c.we;
      bus.core_addr_Q103H  = c.addr;
      bus.core_wdata_Q103H = c.wdata;
      bus.core_be_Q103H    = c.be;
      bus.aux_req          = a.req;
      bus.aux_we           = a.we;
      bus.aux_addr         = a.addr;
      bus.aux_wdata        = a.wdata;
      bus.aux_be           = a.be;
   endtask

   task automatic check_rsp(input string tag);
      rsp_t e;
      e = '{own: NONE, data: 32'h0};
      if (sb.size() > 0) e = sb.pop_front();
      chk({tag, "/core_rvalid"}, 32'(bus.core_rvalid_Q104H), 32'(e.own == CORE));
      chk({tag, "/aux_rvalid"},  32'(bus.aux_rvalid),        32'(e.own == AUX));
      chk({tag, "/core_rdata"},  bus.core_rdata_Q104H, (e.own == CORE) ? e.data : 32'h0);
      chk({tag, "/aux_rdata"},   bus.aux_rdata,        (e.own == AUX)  ? e.data : 32'h0);
   endtask

   // One arbitration cycle: entered and left at posedge+1.
   task automatic cycle(input req_t c, input req_t a, input logic ec, input logic ea,
                        input string tag);
      req_t s;
      drive(c, a);
      @(negedge clk);
      check_rsp(tag);
      chk({tag, "/aux_gnt"},   32'(bus.aux_gnt),          32'(ea));
      chk({tag, "/stall"},     32'(bus.core_stall_Q103H), 32'(c.req & ~ec));
      chk({tag, "/mem_cs"},    32'(bus.mem_cs),           32'(ec | ea));
      s = ec ? c : (ea ? a : IDLE);
      chk({tag, "/mem_we"},    32'(bus.mem_we),    32'(s.we));
      chk({tag, "/mem_addr"},  bus.mem_addr,       s.addr);
      chk({tag, "/mem_wdata"}, bus.mem_wdata,      s.wdata);
      chk({tag, "/mem_be"},    32'(bus.mem_be),    32'(s.be));
      pend = (ec | ea) & ~s.we;
      pidx = s.addr[9:2];
      if (pend) sb.push_back('{own: (ec ? CORE : AUX), data: model[pidx]});
      if ((ec | ea) && s.we)
         for (int b = 0; b < 4; b++)
            if (s.be[b]) model[pidx][8*b +: 8] = s.wdata[8*b +: 8];
      @(posedge clk);
      #1;
      bus.mem_rdata = pend ? model[pidx] : JUNK;
   endtask

   initial begin
      rst = 1'b1;
      drive(IDLE, IDLE);
      bus.mem_rdata = JUNK;
      pend = 1'b0;
      pidx = '0;
      for (int i = 0; i < 256; i++) model[i] = 32'hC0DE_0000 | 32'(i);
      model[8'h40] = 32'hDEAD_BEEF;

      repeat (2) @(negedge clk);
      chk("rst/core_rvalid", 32'(bus.core_rvalid_Q104H), 32'h0);
      chk("rst/aux_rvalid",  32'(bus.aux_rvalid),        32'h0);
      chk("rst/core_rdata",  bus.core_rdata_Q104H,       32'h0);
      chk("rst/aux_rdata",   bus.aux_rdata,              32'h0);
      chk("rst/mem_cs",      32'(bus.mem_cs),            32'h0);
      chk("rst/stall",       32'(bus.core_stall_Q103H),  32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      cycle(ld(32'h100), IDLE, 1'b1, 1'b0, "core_ld");
      cycle(IDLE, IDLE, 1'b0, 1'b0, "core_ld_rsp");

      cycle(st(32'h200, 32'h1234_5678, 4'b0011), IDLE, 1'b1, 1'b0, "core_st");
      cycle(IDLE, IDLE, 1'b0, 1'b0, "core_st_norsp");

      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0)
            cycle(ld(32'h300 + 32'(4 * i)), IDLE, 1'b1, 1'b0, "alt_core");
         else
            cycle(IDLE, ld(32'h200 + 32'(4 * (i - 1))), 1'b0, 1'b1, "alt_aux");
      end
      cycle(IDLE, IDLE, 1'b0, 1'b0, "alt_drain");

      cycle(IDLE, st(32'h040, 32'hAABB_CCDD, 4'b1100), 1'b0, 1'b1, "aux_st");
      cycle(IDLE, ld(32'h040), 1'b0, 1'b1, "aux_ld");
      cycle(IDLE, IDLE, 1'b0, 1'b0, "aux_ld_rsp");

      for (int k = 0; k < 10; k++)
         cycle(ld(32'h400 + 32'(4 * k)), ld(32'h500 + 32'(4 * k)), (k != 8), (k == 8), "starve");
      cycle(IDLE, IDLE, 1'b0, 1'b0, "starve_drain");

      for (int k = 0; k < 8; k++)
         cycle(ld(32'h600 + 32'(4 * k)), ld(32'h700 + 32'(4 * k)), 1'b1, 1'b0, "pre_drop");
      cycle(ld(32'h680), IDLE, 1'b1, 1'b0, "aux_drop");
      for (int k = 0; k < 9; k++)
         cycle(ld(32'h620 + 32'(4 * k)), ld(32'h720 + 32'(4 * k)), (k != 8), (k == 8), "restart");
      cycle(IDLE, IDLE, 1'b0, 1'b0, "restart_drain");

      for (int k = 0; k < 5; k++)
         cycle(ld(32'h800 + 32'(4 * k)), ld(32'h900 + 32'(4 * k)), 1'b1, 1'b0, "pre_rst");
      drive(ld(32'h120), IDLE);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst/core_rvalid", 32'(bus.core_rvalid_Q104H), 32'h0);
      chk("mid_rst/aux_rvalid",  32'(bus.aux_rvalid),        32'h0);
      chk("mid_rst/core_rdata",  bus.core_rdata_Q104H,       32'h0);
      chk("mid_rst/aux_rdata",   bus.aux_rdata,              32'h0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.mem_rdata = model[8'h48];
      for (int k = 0; k < 9; k++)
         cycle(ld(32'hA00 + 32'(4 * k)), ld(32'hB00 + 32'(4 * k)), (k != 8), (k == 8), "post_rst");
      cycle(IDLE, IDLE, 1'b0, 1'b0, "final_drain");
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_dmem_arb.md
RV_DMEM_ARB -- requirements
Module: rv_dmem_arb

Interface
REQ-001 Parameter AUX_WAIT_MAX, default 8, sets the aux-requester wait cycles before aux is forced priority; legal range 1..255.
REQ-002 clk  input  1  pipeline clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 core_req_Q103H  input  1  memory stage requests D_MEM this cycle.
REQ-005 core_we_Q103H  input  1  1=store, 0=load.
REQ-006 core_addr_Q103H  input  32  byte address; word-aligned use of [31:2].
REQ-007 core_wdata_Q103H  input  32  store data.
REQ-008 core_be_Q103H  input  4  store byte enables.
REQ-009 core_stall_Q103H  output  1  core request present but not granted.
REQ-010 core_rdata_Q104H  output  32  load data.
REQ-011 core_rvalid_Q104H  output  1  core_rdata_Q104H valid.
REQ-012 aux_req, aux_we, aux_addr[32], aux_wdata[32], aux_be[4]  input  secondary (loader/debug) port, same meaning as core.
REQ-013 aux_gnt  output  1  aux request accepted this cycle.
REQ-014 aux_rdata  output  32  aux load data; aux_rvalid  output  1  aux_rdata valid.
REQ-015 mem_cs, mem_we, mem_addr[32], mem_wdata[32], mem_be[4]  output  single-port SRAM command.
REQ-016 mem_rdata  input  32  SRAM read data, fixed 1-cycle latency after mem_cs with mem_we=0.

Function
REQ-017 At most one requester SHALL be granted per cycle; mem_cs equals (core granted OR aux granted), same cycle, combinational from inputs and state.
REQ-018 Grant is visible as the core being granted when core_req_Q103H=1 and core_stall_Q103H=0.
REQ-019 Default policy: core has priority; aux granted only when core_req_Q103H=0, or in AUX_PRIO.
REQ-020 FSM states: CORE_PRIO, AUX_PRIO; reset state CORE_PRIO.
REQ-021 wait_cnt (8 bits) SHALL increment each cycle aux_req=1 and aux_gnt=0, and clear to 0 on aux_gnt or aux_req=0.
REQ-022 CORE_PRIO -> AUX_PRIO when wait_cnt reaches AUX_WAIT_MAX-1 and aux is denied again this cycle; AUX_PRIO grants aux unconditionally (core stalls), then returns to CORE_PRIO next cycle.
REQ-023 If aux_req drops while in AUX_PRIO, no aux grant; core granted if requesting; return to CORE_PRIO.
REQ-024 Selected requester's we/addr/wdata/be SHALL drive mem_* unchanged; mem_* SHALL be 0 when mem_cs=0.
REQ-025 rd_owner register (NONE/CORE/AUX) SHALL capture the owner of each granted load; next cycle the matching rvalid=1 with rdata=mem_rdata; the other port's rdata=0, rvalid=0.
REQ-026 Stores SHALL produce no rvalid.
REQ-027 Back-to-back loads from either port SHALL be accepted every cycle (full throughput, no bubble).
REQ-028 core_stall_Q103H SHALL NOT depend on mem_rdata (no combinational loop via SRAM).

Reset
REQ-029 On rst: FSM=CORE_PRIO, wait_cnt=0, rd_owner=NONE; core_rvalid_Q104H=0, aux_rvalid=0, rdata outputs=0, asynchronously.
REQ-030 A load granted in the cycle rst asserts SHALL produce no rvalid after reset release.

Structure
REQ-031 t_dmem_owner enum (NONE, CORE, AUX) and t_dmem_arb_state enum SHALL live in pkg.
REQ-032 All flops use the team DFF macro set with async reset; no sub-module is required.

Verification
REQ-033 Core load addr 0x100 alone, mem_rdata=0xDEADBEEF next cycle -> core_rvalid_Q104H=1, core_rdata_Q104H=0xDEADBEEF, aux_rvalid=0.
REQ-034 Core and aux request same cycle, AUX_WAIT_MAX=8, core requesting continuously -> aux denied cycles 0..7, aux_gnt=1 and core_stall_Q103H=1 on cycle 8, core granted cycle 9.
REQ-035 Alternating core load/aux load every cycle with core idle on aux cycles -> each rvalid routed to correct port, no lost responses.
REQ-036 Core store be=4'b0011 wdata=0x12345678 -> mem_we=1, mem_be=4'b0011, no rvalid next cycle.
REQ-037 Assert rst with wait_cnt=5 and a load in flight -> all rvalid=0 after reset, next arbitration starts in CORE_PRIO with wait_cnt=0.
REQ-038 Aux drops aux_req on the cycle FSM enters AUX_PRIO -> core granted that cycle, aux_gnt=0, FSM returns to CORE_PRIO.
